// File: rtl/booth_r4_mult.sv
// rtl/booth_r4_mult.sv - radix-4 Booth sequential multiplier with valid/ready handshakes
//
// Purpose: multiplies op_a by op_b (signed or unsigned per operation),
// retiring two multiplier bits per clock. Product width is 2N and exact.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operation presented
//   in_ready     idle and able to accept an operation
//   op_a         multiplicand, N bits
//   op_b         multiplier, N bits
//   signed_mode  1 = two's complement operands, 0 = unsigned operands
//   busy         operation in flight or result waiting
//   out_valid    product valid, held until accepted
//   out_ready    consumer accepts the product
//   product      2N-bit product, held until the next result or reset
module booth_r4_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   op_a,
  input  logic [N-1:0]   op_b,
  input  logic           signed_mode,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  // Extended operand width: always even and at least one bit wider than N,
  // so zero-extended unsigned operands read as non-negative signed values.
  localparam int W  = (N % 2 == 0) ? N + 2 : N + 1;
  localparam int K  = W / 2;
  localparam int CW = $clog2(K + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] step;
  logic [W:0]    mcand;     // sign-extended multiplicand, room for +-2M
  logic [2*W:0]  acc;       // {upper half, multiplier, Booth bit q[-1]}

  logic [W-1:0]  a_ext;
  logic [W-1:0]  b_ext;
  logic [W+1:0]  m1;
  logic [W+1:0] m2;
  logic [W+1:0]  sel;
  logic [W+1:0]  sum;
  logic [2*W:0]  acc_next;

  always_comb begin
    a_ext = signed_mode ? {{(W-N){op_a[N-1]}}, op_a} : {{(W-N){1'b0}}, op_a};
    b_ext = signed_mode ? {{(W-N){op_b[N-1]}}, op_b} : {{(W-N){1'b0}}, op_b};
    m1    = {mcand[W], mcand};
    m2    = {mcand, 1'b0};
    case (acc[2:0])
      3'b001, 3'b010: sel = m1;
      3'b011:         sel = m2;
      3'b100:         sel = '0 - m2;
      3'b101, 3'b110: sel = '0 - m1;
      default:        sel = '0;
    endcase
    // Upper half is sign-extended by two bits so the +-2M sum cannot wrap;
    // the arithmetic shift by 2 then drops those bits back out.
    sum      = {{2{acc[2*W]}}, acc[2*W:W+1]} + sel;
    acc_next = {sum, acc[W:2]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      step    <= '0;
      mcand   <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mcand <= {a_ext[W-1], a_ext};
            acc   <= {{W{1'b0}}, b_ext, 1'b0};
            step  <= '0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          acc  <= acc_next;
          step <= step + CW'(1);
          if (step == CW'(K - 1)) begin
            product <= acc_next[2*N:1];
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_booth_r4_mult.sv
// tb/tb_booth_r4_mult.sv - self-checking bench for booth_r4_mult at N=8, N=7 and N=16
module tb_booth_r4_mult;

  logic        clk;
  logic        rst_n;
  logic        iv  [3];
  logic        orr [3];
  logic        sm  [3];
  logic [15:0] oa  [3];
  logic [15:0] ob  [3];
  logic        ir  [3];
  logic        bz  [3];
  logic        ov  [3];
  logic [15:0] p0;
  logic [13:0] p1;
  logic [31:0] p2;
  logic [31:0] pw  [3];

  assign pw[0] = {16'd0, p0};
  assign pw[1] = {18'd0, p1};
  assign pw[2] = p2;

  booth_r4_mult #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .op_a(oa[0][7:0]), .op_b(ob[0][7:0]), .signed_mode(sm[0]), .busy(bz[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .product(p0));

  booth_r4_mult #(.N(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .op_a(oa[1][6:0]), .op_b(ob[1][6:0]), .signed_mode(sm[1]), .busy(bz[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .product(p1));

  booth_r4_mult #(.N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .op_a(oa[2]), .op_b(ob[2]), .signed_mode(sm[2]), .busy(bz[2]),
    .out_valid(ov[2]), .out_ready(orr[2]), .product(p2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: per instance, whether an operation is in flight,
  // edges left until the result, and the expected product register.
  bit          m_busy [3];
  bit          m_done [3];
  int          m_left [3];
  logic [31:0] m_prod [3];
  logic [31:0] m_pend [3];
  int          xfer   [3];

  function automatic int nof(int i);
    return (i == 0) ? 8 : (i == 1) ? 7 : 16;
  endfunction

  function automatic int kof(int i);
    return (i == 0) ? 5 : (i == 1) ? 4 : 9;
  endfunction

  function automatic logic [31:0] ref_prod(int n, logic [15:0] a, logic [15:0] b, bit s);
    longint av, bv, m;
    m  = (longint'(1) << n) - 1;
    av = longint'(a) & m;
    bv = longint'(b) & m;
    if (s && av[n-1]) av = av - (longint'(1) << n);
    if (s && bv[n-1]) bv = bv - (longint'(1) << n);
    return 32'((av * bv) & ((longint'(1) << (2 * n)) - 1));
  endfunction

  function automatic logic [15:0] pick(int n);
    int r = $urandom_range(0, 7);
    logic [15:0] v;
    case (r)
      0:       v = 16'd0;
      1:       v = 16'hFFFF;
      2:       v = 16'(1) << (n - 1);
      3:       v = (16'(1) << (n - 1)) - 16'd1;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Compare process: checks every output of every instance on each falling
  // edge, then advances the model with the inputs the next rising edge sees.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_left[i] = 0;
        m_prod[i] = 32'd0;
      end
      chk($sformatf("n%0d in_ready", nof(i)),  {31'd0, ir[i]}, {31'd0, !m_busy[i]});
      chk($sformatf("n%0d busy", nof(i)),      {31'd0, bz[i]}, {31'd0, m_busy[i]});
      chk($sformatf("n%0d out_valid", nof(i)), {31'd0, ov[i]}, {31'd0, m_done[i]});
      chk($sformatf("n%0d product", nof(i)),   pw[i], m_prod[i]);
      if (rst_n) begin
        if (!m_busy[i]) begin
          if (iv[i]) begin
            m_busy[i] = 1'b1;
            m_left[i] = kof(i);
            m_pend[i] = ref_prod(nof(i), oa[i], ob[i], sm[i]);
          end
        end else if (!m_done[i]) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_done[i] = 1'b1;
            m_prod[i] = m_pend[i];
          end
        end else if (orr[i]) begin
          m_done[i] = 1'b0;
          m_busy[i] = 1'b0;
          xfer[i]++;
        end
      end
    end
  end

  // Called just after a rising edge; returns idle when out_ready is high.
  task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic s, output logic [31:0] p, output int lat);
    int g = 0;
    while (!ir[i] && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk($sformatf("n%0d idle before op", nof(i)), {31'd0, ir[i]}, 32'd1);
    iv[i] = 1'b1; oa[i] = a; ob[i] = b; sm[i] = s;
    @(posedge clk); #1;
    iv[i] = 1'b0; oa[i] = ~a; ob[i] = 16'($urandom); sm[i] = ~s;
    lat = 0;
    while (!ov[i] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    p = pw[i];
    if (orr[i]) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    logic [31:0] p;
    int lat;
    int g;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; orr[i] = 1'b1; sm[i] = 1'b0; oa[i] = 16'd0; ob[i] = 16'd0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("n%0d reset in_ready", nof(i)),  {31'd0, ir[i]}, 32'd1);
      chk($sformatf("n%0d reset busy", nof(i)),      {31'd0, bz[i]}, 32'd0);
      chk($sformatf("n%0d reset out_valid", nof(i)), {31'd0, ov[i]}, 32'd0);
      chk($sformatf("n%0d reset product", nof(i)),   pw[i], 32'd0);
    end

    chk("model 80*80 s8",   ref_prod(8, 16'h80, 16'h80, 1'b1), 32'h4000);
    chk("model ff*ff u8",   ref_prod(8, 16'hFF, 16'hFF, 1'b0), 32'hFE01);
    chk("model ff*ff s8",   ref_prod(8, 16'hFF, 16'hFF, 1'b1), 32'h0001);
    chk("model 7f*7f s7",   ref_prod(7, 16'h7F, 16'h7F, 1'b1), 32'h0001);
    chk("model 80*7f s8",   ref_prod(8, 16'h80, 16'h7F, 1'b1), 32'hC080);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(0, 16'h80, 16'h80, 1'b1, p, lat);
    chk("t1 product", p, 32'h4000);
    chk("t1 latency", 32'(lat), 32'd5);
    run_op(0, 16'hFF, 16'hFF, 1'b0, p, lat);
    chk("t2 unsigned product", p, 32'hFE01);
    run_op(0, 16'hFF, 16'hFF, 1'b1, p, lat);
    chk("t2 signed product", p, 32'h0001);
    run_op(0, 16'h80, 16'h7F, 1'b1, p, lat);
    chk("t3 product", p, 32'hC080);
    run_op(0, 16'h7F, 16'h80, 1'b1, p, lat);
    chk("t3 swapped product", p, 32'hC080);

    // Backpressure with an ignored in_valid pulse during CALC.
    orr[0] = 1'b0;
    iv[0] = 1'b1; oa[0] = 16'h12; ob[0] = 16'h34; sm[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0; oa[0] = 16'h00; ob[0] = 16'h00; sm[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b1; oa[0] = 16'h11; ob[0] = 16'h22; sm[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    g = 0;
    while (!ov[0] && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    chk("t4 out_valid rise", {31'd0, ov[0]}, 32'd1);
    repeat (10) begin
      @(posedge clk); #1;
      chk("t4 hold out_valid", {31'd0, ov[0]}, 32'd1);
      chk("t4 hold product", pw[0], 32'h03A8);
    end
    orr[0] = 1'b1;
    @(posedge clk); #1;
    chk("t4 out_valid after transfer", {31'd0, ov[0]}, 32'd0);
    chk("t4 in_ready after transfer", {31'd0, ir[0]}, 32'd1);
    repeat (8) begin
      @(posedge clk); #1;
      chk("t4 no second result", {31'd0, ov[0]}, 32'd0);
    end

    // Asynchronous reset in the middle of CALC.
    iv[0] = 1'b1; oa[0] = 16'h55; ob[0] = 16'h66; sm[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t5 reset in_ready", {31'd0, ir[0]}, 32'd1);
    chk("t5 reset busy", {31'd0, bz[0]}, 32'd0);
    chk("t5 reset out_valid", {31'd0, ov[0]}, 32'd0);
    chk("t5 reset product", pw[0], 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(0, 16'h03, 16'h05, 1'b0, p, lat);
    chk("t5 product after reset", p, 32'h000F);
    chk("t5 latency after reset", 32'(lat), 32'd5);

    run_op(1, 16'h40, 16'h40, 1'b1, p, lat);
    chk("n7 min*min product", p, 32'h1000);
    chk("n7 latency", 32'(lat), 32'd4);
    run_op(1, 16'h7F, 16'h7F, 1'b0, p, lat);
    chk("n7 max unsigned product", p, 32'h3F01);
    run_op(2, 16'h8000, 16'h8000, 1'b1, p, lat);
    chk("n16 min*min product", p, 32'h40000000);
    chk("n16 latency", 32'(lat), 32'd9);
    run_op(2, 16'hFFFF, 16'hFFFF, 1'b0, p, lat);
    chk("n16 max unsigned product", p, 32'hFFFE0001);

    // Random traffic with random backpressure; the compare process checks it.
    for (int i = 0; i < 3; i++) begin
      xfer[i] = 0;
      repeat (3000) begin
        iv[i]  = 1'($urandom_range(0, 1));
        oa[i]  = pick(nof(i));
        ob[i]  = pick(nof(i));
        sm[i]  = 1'($urandom_range(0, 1));
        orr[i] = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
      iv[i]  = 1'b0;
      orr[i] = 1'b1;
      repeat (20) begin
        @(posedge clk); #1;
      end
      chk($sformatf("n%0d random transfers", nof(i)), {31'd0, xfer[i] > 100}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
